// File: rtl/main_decoder_seq.sv
// main_decoder_seq: registered main decoder with a multi-beat sequencer for
// vector memory ops (ldrv/strv). A vector op moves LANES byte lanes over a
// BEAT_LANES-wide memory port, one beat per cycle; fetch/decode is held
// (StallD) until the last beat issues, and a new instruction may be accepted
// during that last beat so it issues with no bubble.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   InstrValid      decode-stage instruction present
//   Opcode, Func    instruction opcode (6b) and function field (3b)
//   FlushD          squash decode/sequencer; wins over InstrValid
//   StallD          hold fetch/decode (from registered state only)
//   CtrlValid       registered control word valid
//   RegW..ImmSrc    registered execute-stage controls
//   BeatIdx         current beat of a vector memory op, 0 otherwise
//   LastBeat        final (or only) beat of the current control word
//   Illegal         one-cycle pulse for an accepted unimplemented opcode
module main_decoder_seq #(
  parameter int unsigned LANES      = 16,
  parameter int unsigned BEAT_LANES = 4,
  parameter int unsigned BW         = ((LANES / BEAT_LANES) > 1) ? $clog2(LANES / BEAT_LANES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          InstrValid,
  input  logic [5:0]    Opcode,
  input  logic [2:0]    Func,
  input  logic          FlushD,
  output logic          StallD,
  output logic          CtrlValid,
  output logic          RegW,
  output logic          RegWV,
  output logic          MemtoReg,
  output logic          MemW,
  output logic          MemSrc,
  output logic          MemData,
  output logic          MemDataV,
  output logic          VecData,
  output logic          Branch,
  output logic          ALUOp,
  output logic          ALUSrc,
  output logic [1:0]    RegSrc,
  output logic [1:0]    ImmSrc,
  output logic [BW-1:0] BeatIdx,
  output logic          LastBeat,
  output logic          Illegal
);

  localparam int unsigned   NBEATS     = LANES / BEAT_LANES;
  localparam bit            MULTI_BEAT = (NBEATS > 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEATS - 1);

  typedef enum logic {IDLE, VMEM} state_t;

  // Control word held across the beats of a vector op. RegWV is kept apart
  // because for ldrv it only asserts on the final beat.
  typedef struct packed {
    logic       regW;
    logic       memtoReg;
    logic       memW;
    logic       memSrc;
    logic       memData;
    logic       memDataV;
    logic       vecData;
    logic       branch;
    logic       aluOp;
    logic       aluSrc;
    logic [1:0] regSrc;
    logic [1:0] immSrc;
    logic       illegal;
  } ctrl_t;

  state_t        state;
  ctrl_t         ctrlQ;
  ctrl_t         decWord;
  logic          decRegWV;
  logic          decMulti;
  logic          ctrlValidQ;
  logic          regWVQ;
  logic          lastQ;
  logic [BW-1:0] beatQ;
  logic          unusedFunc;

  assign unusedFunc = Func[2];

  always_comb begin
    decWord  = '0;
    decRegWV = 1'b0;
    decMulti = 1'b0;
    casez (Opcode)
      6'b000000: begin
        decWord.regW  = 1'b1;
        decWord.aluOp = 1'b1;
        if (Func[1:0] == 2'b11) begin
          decWord.aluSrc = 1'b1;
          decWord.immSrc = 2'b11;
        end
      end
      6'b100000: begin
        decRegWV      = 1'b1;
        decWord.aluOp = 1'b1;
      end
      6'b0010??: begin
        decWord.regW   = 1'b1;
        decWord.aluOp  = 1'b1;
        decWord.aluSrc = 1'b1;
      end
      6'b011000: begin
        decWord.memW   = 1'b1;
        decWord.aluSrc = 1'b1;
        decWord.regSrc = 2'b01;
      end
      6'b011001: begin
        decWord.regW     = 1'b1;
        decWord.memtoReg = 1'b1;
        decWord.aluSrc   = 1'b1;
      end
      6'b111000: begin
        decWord.memW   = 1'b1;
        decWord.memSrc = 1'b1;
        decWord.aluSrc = 1'b1;
        decWord.regSrc = 2'b01;
        decMulti       = 1'b1;
      end
      6'b111001: begin
        decWord.memtoReg = 1'b1;
        decWord.memSrc   = 1'b1;
        decWord.vecData  = 1'b1;
        decWord.aluSrc   = 1'b1;
        // A single-beat ldrv is its own last beat.
        decRegWV         = ~MULTI_BEAT;
        decMulti         = 1'b1;
      end
      6'b001100, 6'b001101: begin
        decWord.branch = 1'b1;
        decWord.aluOp  = 1'b1;
        decWord.regSrc = 2'b01;
      end
      6'b000100: begin
        decWord.branch = 1'b1;
        decWord.immSrc = 2'b01;
      end
      default: decWord.illegal = 1'b1;
    endcase
  end

  // Mid-sequence beats take priority; otherwise (IDLE or the last beat) the
  // stage is free to accept, which is what gives back-to-back issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctrlQ      <= '0;
      ctrlValidQ <= 1'b0;
      regWVQ     <= 1'b0;
      lastQ      <= 1'b0;
      beatQ      <= '0;
    end else if (FlushD) begin
      state      <= IDLE;
      ctrlQ      <= '0;
      ctrlValidQ <= 1'b0;
      regWVQ     <= 1'b0;
      lastQ      <= 1'b0;
      beatQ      <= '0;
    end else if (state == VMEM && beatQ != LAST_BEAT) begin
      beatQ      <= beatQ + BW'(1);
      ctrlValidQ <= 1'b1;
      if (beatQ + BW'(1) == LAST_BEAT) begin
        lastQ  <= 1'b1;
        regWVQ <= ctrlQ.vecData;
      end
    end else if (InstrValid) begin
      ctrlQ      <= decWord;
      ctrlValidQ <= 1'b1;
      beatQ      <= '0;
      if (decMulti && MULTI_BEAT) begin
        state  <= VMEM;
        lastQ  <= 1'b0;
        regWVQ <= 1'b0;
      end else begin
        state  <= IDLE;
        lastQ  <= 1'b1;
        regWVQ <= decRegWV;
      end
    end else begin
      state      <= IDLE;
      ctrlQ      <= '0;
      ctrlValidQ <= 1'b0;
      regWVQ     <= 1'b0;
      lastQ      <= 1'b0;
      beatQ      <= '0;
    end
  end

  assign StallD    = (state == VMEM) && (beatQ != LAST_BEAT);
  assign CtrlValid = ctrlValidQ;
  assign RegW      = ctrlQ.regW;
  assign RegWV     = regWVQ;
  assign MemtoReg  = ctrlQ.memtoReg;
  assign MemW      = ctrlQ.memW;
  assign MemSrc    = ctrlQ.memSrc;
  assign MemData   = ctrlQ.memData;
  assign MemDataV  = ctrlQ.memDataV;
  assign VecData   = ctrlQ.vecData;
  assign Branch    = ctrlQ.branch;
  assign ALUOp     = ctrlQ.aluOp;
  assign ALUSrc    = ctrlQ.aluSrc;
  assign RegSrc    = ctrlQ.regSrc;
  assign ImmSrc    = ctrlQ.immSrc;
  assign BeatIdx   = beatQ;
  assign LastBeat  = lastQ;
  assign Illegal   = ctrlQ.illegal;

endmodule

// File: tb/tb_main_decoder_seq.sv
// Directed bench for main_decoder_seq: one instance with 4 beats per vector
// op and one with a single beat. Expected output words are queued as each
// stimulus is driven and popped/compared one clock later.
module tb_main_decoder_seq;

  // Packed observation: {ctrlValid, regW, regWV, memtoReg, memW, memSrc,
  // memData, memDataV, vecData, branch, aluOp, aluSrc} regSrc immSrc beatIdx
  // lastBeat illegal stallD
  typedef struct packed {
    logic [11:0] f;
    logic [1:0]  regSrc;
    logic [1:0]  immSrc;
    logic [1:0]  beatIdx;
    logic        lastBeat;
    logic        illegal;
    logic        stallD;
  } obs_t;

  localparam logic [11:0] F_ZERO = 12'b0000_0000_0000;
  localparam logic [11:0] F_ADDI = 12'b1100_0000_0011;
  localparam logic [11:0] F_ALU  = 12'b1100_0000_0010;
  localparam logic [11:0] F_VALU = 12'b1010_0000_0010;
  localparam logic [11:0] F_LDR  = 12'b1101_0000_0001;
  localparam logic [11:0] F_STR  = 12'b1000_1000_0001;
  localparam logic [11:0] F_LDRV = 12'b1001_0100_1001;
  localparam logic [11:0] F_LDRL = 12'b1011_0100_1001;
  localparam logic [11:0] F_STRV = 12'b1000_1100_0001;
  localparam logic [11:0] F_BEQ  = 12'b1000_0000_0110;
  localparam logic [11:0] F_B    = 12'b1000_0000_0100;
  localparam logic [11:0] F_ILL  = 12'b1000_0000_0000;

  logic clk;
  logic rst;

  logic       instrValid, flushD;
  logic [5:0] opcode;
  logic [2:0] func;
  logic       stallD, ctrlValid, regW, regWV, memtoReg, memW, memSrc, memData;
  logic       memDataV, vecData, branch, aluOp, aluSrc, lastBeat, illegal;
  logic [1:0] regSrc, immSrc, beatIdx;

  logic       instrValid1, flushD1;
  logic [5:0] opcode1;
  logic [2:0] func1;
  logic       stallD1, ctrlValid1, regW1, regWV1, memtoReg1, memW1, memSrc1, memData1;
  logic       memDataV1, vecData1, branch1, aluOp1, aluSrc1, lastBeat1, illegal1;
  logic [1:0] regSrc1, immSrc1;
  logic [0:0] beatIdx1;

  obs_t obs0, obs1;
  obs_t q0[$];
  obs_t q1[$];
  int   nComp = 0;
  int   nFail = 0;

  main_decoder_seq #(.LANES(16), .BEAT_LANES(4)) dut (
    .clk(clk), .rst(rst), .InstrValid(instrValid), .Opcode(opcode), .Func(func),
    .FlushD(flushD), .StallD(stallD), .CtrlValid(ctrlValid), .RegW(regW),
    .RegWV(regWV), .MemtoReg(memtoReg), .MemW(memW), .MemSrc(memSrc),
    .MemData(memData), .MemDataV(memDataV), .VecData(vecData), .Branch(branch),
    .ALUOp(aluOp), .ALUSrc(aluSrc), .RegSrc(regSrc), .ImmSrc(immSrc),
    .BeatIdx(beatIdx), .LastBeat(lastBeat), .Illegal(illegal)
  );

  main_decoder_seq #(.LANES(16), .BEAT_LANES(16)) dut1 (
    .clk(clk), .rst(rst), .InstrValid(instrValid1), .Opcode(opcode1), .Func(func1),
    .FlushD(flushD1), .StallD(stallD1), .CtrlValid(ctrlValid1), .RegW(regW1),
    .RegWV(regWV1), .MemtoReg(memtoReg1), .MemW(memW1), .MemSrc(memSrc1),
    .MemData(memData1), .MemDataV(memDataV1), .VecData(vecData1), .Branch(branch1),
    .ALUOp(aluOp1), .ALUSrc(aluSrc1), .RegSrc(regSrc1), .ImmSrc(immSrc1),
    .BeatIdx(beatIdx1), .LastBeat(lastBeat1), .Illegal(illegal1)
  );

  assign obs0 = {ctrlValid, regW, regWV, memtoReg, memW, memSrc, memData, memDataV,
                 vecData, branch, aluOp, aluSrc, regSrc, immSrc, beatIdx,
                 lastBeat, illegal, stallD};
  assign obs1 = {ctrlValid1, regW1, regWV1, memtoReg1, memW1, memSrc1, memData1, memDataV1,
                 vecData1, branch1, aluOp1, aluSrc1, regSrc1, immSrc1, {1'b0, beatIdx1},
                 lastBeat1, illegal1, stallD1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [11:0] f, input logic [1:0] rs, input logic [1:0] is,
                              input logic [1:0] bi, input logic lb, input logic il,
                              input logic st);
    return {f, rs, is, bi, lb, il, st};
  endfunction

  task automatic check0(input string tag);
    obs_t ex;
    nComp++;
    if (q0.size() == 0) begin
      nFail++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs0);
    end else begin
      ex = q0.pop_front();
      assert (obs0 === ex) else begin
        nFail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs0, ex);
      end
    end
  endtask

  task automatic check1(input string tag);
    obs_t ex;
    nComp++;
    if (q1.size() == 0) begin
      nFail++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs1);
    end else begin
      ex = q1.pop_front();
      assert (obs1 === ex) else begin
        nFail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs1, ex);
      end
    end
  endtask

  // Drive one cycle of stimulus on the 4-beat instance, queue the word
  // expected after the next rising edge, then compare it.
  task automatic cyc(input logic v, input logic [5:0] op, input logic [2:0] fn,
                     input logic fl, input obs_t ex, input string tag);
    instrValid = v;
    opcode     = op;
    func       = fn;
    flushD     = fl;
    q0.push_back(ex);
    @(posedge clk);
    #1;
    check0(tag);
  endtask

  task automatic cyc1(input logic v, input logic [5:0] op, input obs_t ex, input string tag);
    instrValid1 = v;
    opcode1     = op;
    func1       = 3'b000;
    flushD1     = 1'b0;
    q1.push_back(ex);
    @(posedge clk);
    #1;
    check1(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    instrValid = 1'b0; opcode = '0; func = '0; flushD = 1'b0;
    instrValid1 = 1'b0; opcode1 = '0; func1 = '0; flushD1 = 1'b0;
    #3;
    q0.push_back('0);
    check0("reset0");
    q1.push_back('0);
    check1("reset1");
    @(negedge clk);
    rst = 1'b0;

    // Scalar decode table
    cyc(1, 6'b000000, 3'b011, 0, mk(F_ADDI, 2'b00, 2'b11, 2'd0, 1, 0, 0), "addi");
    cyc(1, 6'b000000, 3'b000, 0, mk(F_ALU,  2'b00, 2'b00, 2'd0, 1, 0, 0), "alu");
    cyc(0, 6'b000000, 3'b011, 0, '0, "bubble0");
    cyc(1, 6'b100000, 3'b000, 0, mk(F_VALU, 2'b00, 2'b00, 2'd0, 1, 0, 0), "valu");
    cyc(1, 6'b001011, 3'b000, 0, mk(F_ADDI & 12'b1100_0000_0011, 2'b00, 2'b00, 2'd0, 1, 0, 0), "alui");
    cyc(1, 6'b011000, 3'b000, 0, mk(F_STR,  2'b01, 2'b00, 2'd0, 1, 0, 0), "str");
    cyc(1, 6'b001100, 3'b000, 0, mk(F_BEQ,  2'b01, 2'b00, 2'd0, 1, 0, 0), "beq");
    cyc(1, 6'b001101, 3'b000, 0, mk(F_BEQ,  2'b01, 2'b00, 2'd0, 1, 0, 0), "bgt");
    cyc(1, 6'b000100, 3'b000, 0, mk(F_B,    2'b00, 2'b01, 2'd0, 1, 0, 0), "b");

    // ldrv over 4 beats, ldr held until the last beat then issued back-to-back
    cyc(1, 6'b111001, 3'b000, 0, mk(F_LDRV, 2'b00, 2'b00, 2'd0, 0, 0, 1), "ldrv_b0");
    cyc(1, 6'b011001, 3'b000, 0, mk(F_LDRV, 2'b00, 2'b00, 2'd1, 0, 0, 1), "ldrv_b1");
    cyc(1, 6'b011001, 3'b000, 0, mk(F_LDRV, 2'b00, 2'b00, 2'd2, 0, 0, 1), "ldrv_b2");
    cyc(1, 6'b011001, 3'b000, 0, mk(F_LDRL, 2'b00, 2'b00, 2'd3, 1, 0, 0), "ldrv_b3");
    cyc(1, 6'b011001, 3'b000, 0, mk(F_LDR,  2'b00, 2'b00, 2'd0, 1, 0, 0), "ldr_b2b");
    cyc(0, 6'b000000, 3'b000, 0, '0, "bubble1");

    // strv over 4 beats
    cyc(1, 6'b111000, 3'b000, 0, mk(F_STRV, 2'b01, 2'b00, 2'd0, 0, 0, 1), "strv_b0");
    cyc(0, 6'b000000, 3'b000, 0, mk(F_STRV, 2'b01, 2'b00, 2'd1, 0, 0, 1), "strv_b1");
    cyc(0, 6'b000000, 3'b000, 0, mk(F_STRV, 2'b01, 2'b00, 2'd2, 0, 0, 1), "strv_b2");
    cyc(0, 6'b000000, 3'b000, 0, mk(F_STRV, 2'b01, 2'b00, 2'd3, 1, 0, 0), "strv_b3");
    cyc(0, 6'b000000, 3'b000, 0, '0, "bubble2");

    // Flush at beat 1 of strv; the instruction presented with it is dropped
    cyc(1, 6'b111000, 3'b000, 0, mk(F_STRV, 2'b01, 2'b00, 2'd0, 0, 0, 1), "fl_b0");
    cyc(0, 6'b000000, 3'b000, 0, mk(F_STRV, 2'b01, 2'b00, 2'd1, 0, 0, 1), "fl_b1");
    cyc(1, 6'b001011, 3'b000, 1, '0, "flush_vmem");
    cyc(0, 6'b000000, 3'b000, 0, '0, "flush_after");
    cyc(1, 6'b000000, 3'b011, 1, '0, "flush_idle");

    // Illegal opcode pulses once, then a bubble
    cyc(1, 6'b101010, 3'b000, 0, mk(F_ILL, 2'b00, 2'b00, 2'd0, 1, 1, 0), "illegal");
    cyc(0, 6'b101010, 3'b000, 0, '0, "illegal_end");

    // Asynchronous reset at beat 2 of ldrv
    cyc(1, 6'b111001, 3'b000, 0, mk(F_LDRV, 2'b00, 2'b00, 2'd0, 0, 0, 1), "rst_b0");
    cyc(0, 6'b000000, 3'b000, 0, mk(F_LDRV, 2'b00, 2'b00, 2'd1, 0, 0, 1), "rst_b1");
    cyc(0, 6'b000000, 3'b000, 0, mk(F_LDRV, 2'b00, 2'b00, 2'd2, 0, 0, 1), "rst_b2");
    #2;
    rst = 1'b1;
    #1;
    q0.push_back('0);
    check0("async_rst");
    #1;
    rst = 1'b0;
    cyc(1, 6'b000000, 3'b011, 0, mk(F_ADDI, 2'b00, 2'b11, 2'd0, 1, 0, 0), "post_rst");
    cyc(0, 6'b000000, 3'b000, 0, '0, "bubble3");

    // Single-beat configuration: vector ops complete in one cycle, never stall
    cyc1(1, 6'b111001, mk(F_LDRL, 2'b00, 2'b00, 2'd0, 1, 0, 0), "n1_ldrv");
    cyc1(1, 6'b111001, mk(F_LDRL, 2'b00, 2'b00, 2'd0, 1, 0, 0), "n1_ldrv_b2b");
    cyc1(1, 6'b111000, mk(F_STRV, 2'b01, 2'b00, 2'd0, 1, 0, 0), "n1_strv");
    cyc1(1, 6'b011001, mk(F_LDR,  2'b00, 2'b00, 2'd0, 1, 0, 0), "n1_ldr");
    cyc1(0, 6'b000000, '0, "n1_bubble");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
